// File: rtl/mux_dff_pkg.sv
// Shared defaults and select encoding for the registered 2:1 select cell.
package mux_dff_pkg;

  localparam int   MUX_DFF_WIDTH_DEFAULT   = 1;
  localparam logic MUX_DFF_RST_VAL_DEFAULT = 1'b0;

  typedef enum logic {
    SEL_D0 = 1'b0,
    SEL_D1 = 1'b1
  } sel_e;

endpackage

// File: rtl/mux_dff.sv
// Leaf storage element: D flip-flop that captures d1 when sel=1, else d0,
// with a synchronous active-high reset that overrides the select.
module mux_dff
  import mux_dff_pkg::*;
#(
  parameter int                 WIDTH   = MUX_DFF_WIDTH_DEFAULT,
  parameter logic [WIDTH-1:0]   RST_VAL = {WIDTH{MUX_DFF_RST_VAL_DEFAULT}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic             sel,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] q_q;

  always_comb begin
    q_d = (sel == SEL_D1) ? d1 : d0;
  end

  // Reset is sampled only on the clock edge; no enable, so q reloads every cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= RST_VAL;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: tb/tb_mux_dff.sv
// Directed bench for mux_dff: a 1-bit default instance plus a 4-bit instance
// with a non-zero reset value, both sharing clk/rst/sel.
module tb_mux_dff;
  import mux_dff_pkg::*;

  logic       clk;
  logic       rst;
  logic       sel;
  logic [0:0] d0;
  logic [0:0] d1;
  logic [0:0] q;
  logic [3:0] d0w;
  logic [3:0] d1w;
  logic [3:0] qw;

  int checks;
  int failures;

  mux_dff dut (
    .clk (clk),
    .rst (rst),
    .d0  (d0),
    .d1  (d1),
    .sel (sel),
    .q   (q)
  );

  mux_dff #(.WIDTH(4), .RST_VAL(4'h5)) dut_w (
    .clk (clk),
    .rst (rst),
    .d0  (d0w),
    .d1  (d1w),
    .sel (sel),
    .q   (qw)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    d0w      = 4'h3;
    d1w      = 4'hC;

    // Reset with arbitrary select and both data inputs high
    rst = 1'b1; sel = 1'($urandom_range(0, 1)); d0 = 1'b1; d1 = 1'b1;
    step(); chk("rst_edge1", {3'b0, q}, 4'h0);
    chk("rst_wide", qw, 4'h5);
    step(); chk("rst_edge2", {3'b0, q}, 4'h0);

    // Load d0
    rst = 1'b0; sel = SEL_D0; d0 = 1'b1; d1 = 1'b1;
    step(); chk("ld_d0_a", {3'b0, q}, 4'h1);
    chk("ld_d0_wide", qw, 4'h3);
    step(); chk("ld_d0_b", {3'b0, q}, 4'h1);

    // Load d1, then back to d0 = 0
    sel = SEL_D1; d0 = 1'b0; d1 = 1'b1;
    step(); chk("ld_d1_a", {3'b0, q}, 4'h1);
    chk("ld_d1_wide", qw, 4'hC);
    step(); chk("ld_d1_b", {3'b0, q}, 4'h1);
    sel = SEL_D0; d0 = 1'b0;
    step(); chk("ld_d0_zero", {3'b0, q}, 4'h0);
    chk("ld_d0_zero_wide", qw, 4'h3);

    // Alternation: reset, d0, d1, d0, d1
    rst = 1'b1;
    step(); chk("alt_rst", {3'b0, q}, 4'h0);
    rst = 1'b0; sel = SEL_D0; d0 = 1'b1; d1 = 1'b1;
    step(); chk("alt_d0_1", {3'b0, q}, 4'h1);
    sel = SEL_D1; d0 = 1'b0; d1 = 1'b1;
    step(); chk("alt_d1_1", {3'b0, q}, 4'h1);
    sel = SEL_D0; d0 = 1'b1; d1 = 1'b1;
    step(); chk("alt_d0_2", {3'b0, q}, 4'h1);
    sel = SEL_D1; d0 = 1'b0; d1 = 1'b1;
    step(); chk("alt_d1_2", {3'b0, q}, 4'h1);

    // Reset raised mid-cycle takes effect only at the next edge
    rst = 1'b1;
    #2; chk("rst_midcycle_hold", {3'b0, q}, 4'h1);
    chk("rst_midcycle_hold_wide", qw, 4'hC);
    step(); chk("rst_sync_clear", {3'b0, q}, 4'h0);
    chk("rst_sync_clear_wide", qw, 4'h5);
    rst = 1'b0; sel = SEL_D1; d1 = 1'b1;
    step(); chk("rst_release", {3'b0, q}, 4'h1);

    // sel changing mid-cycle only matters at the edge
    sel = SEL_D0; d0 = 1'b0;
    #2; chk("sel_midcycle_hold", {3'b0, q}, 4'h1);
    sel = SEL_D1;
    step(); chk("sel_at_edge", {3'b0, q}, 4'h1);

    // Non-selected input isolation
    sel = SEL_D0; d0 = 1'b1; d1 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      d1 = ~d1;
      step(); chk("iso_d1_toggle", {3'b0, q}, 4'h1);
    end
    sel = SEL_D1; d1 = 1'b0; d0 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      d0 = ~d0;
      step(); chk("iso_d0_toggle", {3'b0, q}, 4'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mux_dff.md
Name: mux_dff

Overview:
- Single-clock D flip-flop with a 2:1 input select: on each rising clock edge, q captures d1 when sel=1 and d0 when sel=0.
- A synchronous active-high reset clears q.
- Used as a leaf storage element wherever a registered 2-way select is needed.
- A single-bit instance is the primary use; the data width is parameterized.

Parameters:
- WIDTH, 1, data width of d0, d1 and q.
- RST_VAL, '0 (all zeros), value loaded into q on reset. Width is WIDTH.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  reset; synchronous, active-high.
- d0   input  WIDTH  data captured when sel=0.
- d1   input  WIDTH  data captured when sel=1.
- sel  input  1  select: 0 picks d0, 1 picks d1.
- q    output  WIDTH  registered output.

Behaviour:
- One clock (clk); reset rst is synchronous and active-high. It is sampled only on the rising clk edge and never acts asynchronously.
- Priority at each rising clk edge:
  - If rst=1: q <= RST_VAL (0 for the default). rst overrides sel, d0 and d1, whatever their values.
  - Else if sel=1: q <= d1.
  - Else: q <= d0.
- Latency: q reflects the selected input exactly one clk edge after that input and sel are sampled. There is no combinational path from any input to q.
- rst asserted between edges: q holds its value until the next rising edge, then clears.
- rst deasserted: normal loading resumes on the first edge where rst=0.
- Changing sel mid-cycle has no effect until the next edge. Only the value present at the edge matters.
- The non-selected input is ignored entirely, e.g. sel=0 with d1 toggling gives no change in q.
- Power-up before the first reset: q is undefined (X in simulation). No initial value is guaranteed, so the bench must apply rst first.
- X handling: if sel is X at an edge while rst=0, q may go X in simulation. No X-masking logic is required.
- q holds its value indefinitely in the absence of new edges. There is no enable: q reloads every edge.
- Implementation: a single always_ff on posedge clk with no reset in the sensitivity list. The output is a plain register with no glitches.

Decomposition:
- Shared package mux_dff_pkg holds:
  - MUX_DFF_WIDTH_DEFAULT = 1
  - MUX_DFF_RST_VAL_DEFAULT = '0
  - typedef sel_e {SEL_D0=1'b0, SEL_D1=1'b1}, used by benches for readable stimulus.
- No sub-module: the 2:1 select is inline within the register process. A separate mux module adds nothing.

Test Plan:
- Reset: rst=1, sel random, d0=1, d1=1, held 2 edges -> q=0 after the first edge and still 0 after the second.
- Load d0: rst=0, sel=0, d0=1, d1=1, held 2 edges -> q=1.
- Load d1: rst=0, sel=1, d0=0, d1=1, held 2 edges -> q=1. Then sel=0, d0=0 -> q=0 after one edge.
- Alternation: sequence reset, d0-load, d1-load, d0-load, d1-load with the values above -> q = 0,1,1,1,1 at each check, with no intermediate X.
- Synchronous reset check: with q=1, raise rst mid-cycle (between edges) -> q stays 1 until the next rising edge, then 0. Drop rst with sel=1, d1=1 -> q=1 one edge later.
- Non-selected input isolation: sel=0, d0=1, toggle d1 every cycle for 4 edges -> q stays 1 throughout. Repeat with sel=1, d1=0 while toggling d0 -> q stays 0.
